// File: rtl/bdc_regmap_pkg.sv
// rtl/bdc_regmap_pkg.sv - register map offsets, global addresses and snapshot FSM encoding
package bdc_regmap_pkg;

  localparam int         CH_STRIDE   = 8;
  localparam logic [2:0] OFF_CNT0    = 3'd0;
  localparam logic [2:0] OFF_CFG     = 3'd6;
  localparam logic [2:0] OFF_STAT    = 3'd7;

  // Globals sit at the top of the address space, counted back from 2**ADDR_W.
  localparam int GLB_HWCFG   = -3;
  localparam int GLB_WDOGDIV = -2;
  localparam int GLB_CTRL    = -1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FROZEN  = 2'd1,
    ST_CAPTURE = 2'd2
  } snap_state_e;

  function automatic logic [7:0] status_byte(input logic lost, input logic frozen);
    return {6'b0, lost, frozen};
  endfunction

endpackage

// File: rtl/reg_bridge_snapshot_if.sv
// rtl/reg_bridge_snapshot_if.sv - SPI-side register bus between spi and the bridge
interface reg_bridge_snapshot_if #(
  parameter int ADDR_W = 5
);
  logic              wrt;
  logic              rdt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rddata;

  modport master (output wrt, rdt, addr, input rddata);
  modport slave  (input wrt, rdt, addr, output rddata);
endinterface

// File: rtl/snapshot_ctl.sv
// rtl/snapshot_ctl.sv - per-channel freeze FSM, tach snapshot register and unread/lost flags
module snapshot_ctl
  import bdc_regmap_pkg::*;
#(
  parameter int CNT_BYTES = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       rs_cnt0,
  input  logic                       re,
  input  logic                       rs_snap,
  input  logic                       clr_lost,
  input  logic [(CNT_BYTES-1)*8-1:0] count_hi,
  output logic                       freeze,
  output logic                       lost,
  output logic [(CNT_BYTES-1)*8-1:0] snap
);

  localparam int SW = (CNT_BYTES - 1) * 8;

  snap_state_e   state_q, state_d;
  logic          freeze_q, freeze_d;
  logic          unread_q, unread_d;
  logic          lost_q, lost_d;
  logic [SW-1:0] snap_q, snap_d;

  // Next state: freeze on a byte0 read, capture the upper bytes when that read ends.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    unread_d = unread_q;
    lost_d   = lost_q;
    if (rs_snap)  unread_d = 1'b0;
    if (clr_lost) lost_d   = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (rs_cnt0) state_d = ST_FROZEN;
      ST_FROZEN:  if (re) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        snap_d   = count_hi;
        unread_d = 1'b1;
        // A set in the same cycle as a software clear must win.
        if (unread_q) lost_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
    freeze_d = (state_d != ST_IDLE);
  end

  // State, flags and the registered freeze output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      freeze_q <= 1'b0;
      unread_q <= 1'b0;
      lost_q   <= 1'b0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
      unread_q <= unread_d;
      lost_q   <= lost_d;
      snap_q   <= snap_d;
    end
  end

  assign freeze = freeze_q;
  assign lost   = lost_q;
  assign snap   = snap_q;

endmodule

// File: rtl/reg_bridge_snapshot.sv
// rtl/reg_bridge_snapshot.sv - SPI strobe sync, address decode, read mux and per-channel snapshots
module reg_bridge_snapshot
  import bdc_regmap_pkg::*;
#(
  parameter int NCHAN     = 3,
  parameter int CNT_BYTES = 2,
  parameter int ADDR_W    = 5
) (
  input  logic                         clk,
  input  logic                         resetn,
  reg_bridge_snapshot_if.slave         bus,
  input  logic [NCHAN*CNT_BYTES*8-1:0] count,
  input  logic [7:0]                   controlrdata,
  input  logic [7:0]                   hwconfig,
  output logic [NCHAN-1:0]             freeze,
  output logic [NCHAN-1:0]             pwmld,
  output logic [NCHAN-1:0]             cfgld,
  output logic                         ctrlld,
  output logic                         wdogdivld,
  output logic                         wdreset
);

  localparam int CW = ADDR_W - 3;
  localparam int SW = (CNT_BYTES - 1) * 8;
  localparam int CB = CNT_BYTES * 8;
  localparam logic [ADDR_W-1:0] A_HWCFG   = ADDR_W'((2 ** ADDR_W) + GLB_HWCFG);
  localparam logic [ADDR_W-1:0] A_WDOGDIV = ADDR_W'((2 ** ADDR_W) + GLB_WDOGDIV);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'((2 ** ADDR_W) + GLB_CTRL);

  if (NCHAN * CH_STRIDE > (2 ** ADDR_W) - 8) begin : g_bad_param
    $error("reg_bridge_snapshot: channel map overlaps the global registers");
  end

  logic [3:0]    wsr_q, wsr_d, rsr_q, rsr_d;
  logic          we, rs, re;
  logic [CW-1:0] ch_idx;
  logic [2:0]    off;
  logic [7:0]    rd;
  logic [NCHAN-1:0] lost_all;
  logic [SW-1:0] snap_all [NCHAN];

  // Shift the sclk-domain strobes into clk; bit 0 is the newest sample.
  always_comb begin
    wsr_d = {wsr_q[2:0], bus.wrt};
    rsr_d = {rsr_q[2:0], bus.rdt};
  end

  // Four-flop synchroniser chains for wrt and rdt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wsr_q <= '0;
      rsr_q <= '0;
    end else begin
      wsr_q <= wsr_d;
      rsr_q <= rsr_d;
    end
  end

  assign we     = wsr_q[3] & ~wsr_q[2];
  assign rs     = rsr_q[2] & ~rsr_q[3];
  assign re     = rsr_q[3] & ~rsr_q[2];
  assign ch_idx = bus.addr[ADDR_W-1:3];
  assign off    = bus.addr[2:0];

  assign ctrlld    = we & (bus.addr == A_CTRL);
  assign wdogdivld = we & (bus.addr == A_WDOGDIV);
  assign wdreset   = rs & (bus.addr == A_CTRL);

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic hit;
    logic snap_off;
    assign hit      = (ch_idx == CW'(c));
    assign snap_off = (off != OFF_CNT0) && (int'(off) < CNT_BYTES);
    assign pwmld[c] = we & hit & (off == OFF_CNT0);
    assign cfgld[c] = we & hit & (off == OFF_CFG);

    snapshot_ctl #(.CNT_BYTES(CNT_BYTES)) u_snap (
      .clk      (clk),
      .resetn   (resetn),
      .rs_cnt0  (rs & hit & (off == OFF_CNT0)),
      .re       (re),
      .rs_snap  (rs & hit & snap_off),
      .clr_lost (we & hit & (off == OFF_STAT)),
      .count_hi (count[c*CB+8 +: SW]),
      .freeze   (freeze[c]),
      .lost     (lost_all[c]),
      .snap     (snap_all[c])
    );
  end

  // Read mux: anything unmapped reads as zero.
  always_comb begin
    rd = 8'h00;
    if (bus.addr == A_HWCFG) begin
      rd = hwconfig;
    end else if (bus.addr == A_CTRL) begin
      rd = controlrdata;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (ch_idx == CW'(c)) begin
          if (off == OFF_CNT0)                rd = count[c*CB +: 8];
          else if (off == OFF_STAT)           rd = status_byte(lost_all[c], freeze[c]);
          else if (int'(off) < CNT_BYTES)     rd = snap_all[c][(int'(off)-1)*8 +: 8];
        end
      end
    end
  end

  assign bus.rddata = rd;

endmodule

// File: tb/tb_reg_bridge_snapshot.sv
// tb/tb_reg_bridge_snapshot.sv - scoreboard bench for reg_bridge_snapshot, default and wide configs
module tb_reg_bridge_snapshot;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  reg_bridge_snapshot_if #(.ADDR_W(5)) bus ();
  reg_bridge_snapshot_if #(.ADDR_W(7)) bus2 ();

  logic [47:0]  count;
  logic [255:0] count2;
  logic [7:0]   controlrdata, hwconfig;
  logic [2:0]   freeze, pwmld, cfgld;
  logic         ctrlld, wdogdivld, wdreset;
  logic [7:0]   freeze2, pwmld2, cfgld2;
  logic         ctrlld2, wdogdivld2, wdreset2;

  reg_bridge_snapshot #(.NCHAN(3), .CNT_BYTES(2), .ADDR_W(5)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .count(count),
    .controlrdata(controlrdata), .hwconfig(hwconfig),
    .freeze(freeze), .pwmld(pwmld), .cfgld(cfgld),
    .ctrlld(ctrlld), .wdogdivld(wdogdivld), .wdreset(wdreset)
  );

  reg_bridge_snapshot #(.NCHAN(8), .CNT_BYTES(4), .ADDR_W(7)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2), .count(count2),
    .controlrdata(controlrdata), .hwconfig(hwconfig),
    .freeze(freeze2), .pwmld(pwmld2), .cfgld(cfgld2),
    .ctrlld(ctrlld2), .wdogdivld(wdogdivld2), .wdreset(wdreset2)
  );

  typedef struct {string name; int sel; logic [31:0] exp;} obs_t;
  typedef struct {string name; logic [8:0] strb; int at;} strb_t;
  obs_t  obs_q[$];
  strb_t strb_q[$];
  int obs_req = 0;
  int obs_seen = 0;
  int checks = 0;
  int errors = 0;

  // Monitor: every strobe pulse is matched against the expected queue; observation requests are popped here.
  always @(negedge clk) begin
    logic [8:0]  s;
    logic [31:0] act;
    obs_t        o;
    strb_t       e;
    s = {pwmld, cfgld, ctrlld, wdogdivld, wdreset};
    if (s !== 9'b0) begin
      checks++;
      if (strb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got %h at cycle %0d, required none", s, cyc);
      end else begin
        e = strb_q.pop_front();
        if (s !== e.strb || cyc != e.at) begin
          errors++;
          $display("FAIL %s: got strobes %h at cycle %0d, required %h at cycle %0d",
                   e.name, s, cyc, e.strb, e.at);
        end
      end
    end
    while (obs_seen != obs_req && obs_q.size() != 0) begin
      o = obs_q.pop_front();
      obs_seen++;
      case (o.sel)
        0:       act = {24'b0, bus.rddata};
        1:       act = {29'b0, freeze};
        2:       act = {24'b0, bus2.rddata};
        default: act = {24'b0, freeze2};
      endcase
      checks++;
      if (act !== o.exp) begin
        errors++;
        $display("FAIL %s: got %h, required %h", o.name, act, o.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input int sel, input logic [31:0] exp, input string name);
    obs_q.push_back('{name, sel, exp});
    obs_req++;
    tick(1);
  endtask

  task automatic chk_rd(input logic [4:0] a, input logic [7:0] exp, input string name);
    bus.addr = a;
    expect_obs(0, {24'b0, exp}, name);
  endtask

  // The strobe is visible in the cycle that begins two edges after the edge first sampling wrt low.
  task automatic do_write(input logic [4:0] a, input logic [8:0] strb, input string name);
    bus.addr = a;
    bus.wrt  = 1'b1;
    tick(5);
    bus.wrt  = 1'b0;
    if (strb != 9'b0) strb_q.push_back('{name, strb, cyc + 3});
    tick(6);
  endtask

  task automatic rd_start(input logic [4:0] a, input logic wd);
    bus.addr = a;
    bus.rdt  = 1'b1;
    if (wd) strb_q.push_back('{"wdreset_pulse", 9'h001, cyc + 3});
    tick(6);
  endtask

  task automatic rd_end();
    bus.rdt = 1'b0;
    tick(6);
  endtask

  task automatic do_read(input logic [4:0] a);
    rd_start(a, 1'b0);
    rd_end();
  endtask

  initial begin
    bus.wrt = 1'b0; bus.rdt = 1'b0; bus.addr = '0;
    bus2.wrt = 1'b0; bus2.rdt = 1'b0; bus2.addr = '0;
    count = '0; count2 = '0;
    controlrdata = 8'hA5; hwconfig = 8'h3C;
    tick(3);

    expect_obs(1, 32'h0, "rst_freeze");
    chk_rd(5'h07, 8'h00, "rst_status0");
    chk_rd(5'h09, 8'h00, "rst_snap1");
    resetn = 1'b1;
    tick(2);

    // Write strobes, {pwmld[2:0], cfgld[2:0], ctrlld, wdogdivld, wdreset}
    do_write(5'h06, 9'h008, "wr_cfgld0");
    do_write(5'h00, 9'h040, "wr_pwmld0");
    do_write(5'h16, 9'h020, "wr_cfgld2");
    do_write(5'h08, 9'h080, "wr_pwmld1");
    do_write(5'h1F, 9'h004, "wr_ctrlld");
    do_write(5'h1E, 9'h002, "wr_wdogdivld");
    do_write(5'h1D, 9'h000, "");
    do_write(5'h05, 9'h000, "");
    do_write(5'h18, 9'h000, "");
    do_write(5'h0B, 9'h000, "");

    // Snapshot on channel 1
    count[16 +: 16] = 16'h12AB;
    rd_start(5'h08, 1'b0);
    expect_obs(1, 32'h2, "snap_freeze1");
    chk_rd(5'h0F, 8'h01, "snap_status_frozen");
    count[16 +: 16] = 16'h3456;
    bus.addr = 5'h08;
    rd_end();
    expect_obs(1, 32'h0, "snap_unfreeze");
    chk_rd(5'h08, 8'h56, "snap_byte0_live");
    chk_rd(5'h09, 8'h34, "snap_byte1");
    count[16 +: 16] = 16'h7788;
    chk_rd(5'h09, 8'h34, "snap_byte1_held");
    chk_rd(5'h0F, 8'h00, "snap_status_idle");
    do_read(5'h09);
    do_read(5'h08);
    chk_rd(5'h0F, 8'h00, "ch1_no_lost");
    chk_rd(5'h09, 8'h77, "ch1_resnap");

    // Lost flag on channel 2, plus a pwmld write while frozen
    count[32 +: 16] = 16'hC0DE;
    do_read(5'h10);
    chk_rd(5'h17, 8'h00, "lost_after_one");
    rd_start(5'h10, 1'b0);
    do_write(5'h10, 9'h100, "wr_pwmld2_frozen");
    expect_obs(1, 32'h4, "frozen_after_pwmld");
    bus.addr = 5'h10;
    rd_end();
    chk_rd(5'h17, 8'h02, "lost_set");
    chk_rd(5'h11, 8'hC0, "ch2_snap");
    do_write(5'h17, 9'h000, "");
    chk_rd(5'h17, 8'h00, "lost_cleared");

    // Globals and unmapped reads
    rd_start(5'h1F, 1'b1);
    expect_obs(0, 32'hA5, "glb_ctrl_rd");
    rd_end();
    chk_rd(5'h1D, 8'h3C, "glb_hwcfg");
    chk_rd(5'h1C, 8'h00, "glb_1c_unmapped");
    chk_rd(5'h1E, 8'h00, "glb_wdog_wo");
    chk_rd(5'h06, 8'h00, "cfg_wo");
    chk_rd(5'h0A, 8'h00, "ch1_off2_unimpl");

    // Reset in the middle of a frozen read
    do_read(5'h10);
    chk_rd(5'h17, 8'h02, "lost_set_again");
    count[0 +: 16] = 16'hBEEF;
    do_read(5'h00);
    chk_rd(5'h01, 8'hBE, "ch0_snap");
    rd_start(5'h00, 1'b0);
    expect_obs(1, 32'h1, "ch0_frozen");
    bus.addr = 5'h01;
    bus.rdt  = 1'b0;
    resetn   = 1'b0;
    expect_obs(1, 32'h0, "rst_async_freeze");
    chk_rd(5'h01, 8'h00, "rst_async_snap");
    chk_rd(5'h17, 8'h00, "rst_lost");
    resetn = 1'b1;
    tick(2);

    // Wide configuration: channel 7 of 8, four-byte counters
    count2[224 +: 32] = 32'h11223344;
    bus2.addr = 7'h38;
    bus2.rdt  = 1'b1;
    tick(6);
    expect_obs(3, 32'h80, "p2_freeze7");
    count2[224 +: 32] = 32'hAABBCCDD;
    bus2.rdt = 1'b0;
    tick(6);
    count2[224 +: 32] = 32'h01020304;
    bus2.addr = 7'h39; expect_obs(2, 32'hCC, "p2_byte1");
    bus2.addr = 7'h3A; expect_obs(2, 32'hBB, "p2_byte2");
    bus2.addr = 7'h3B; expect_obs(2, 32'hAA, "p2_byte3");
    bus2.addr = 7'h3C; expect_obs(2, 32'h00, "p2_off4_unimpl");
    bus2.addr = 7'h38; expect_obs(2, 32'h04, "p2_byte0_live");
    bus2.addr = 7'h7F; expect_obs(2, 32'hA5, "p2_ctrl");

    tick(10);
    while (strb_q.size() != 0) begin
      strb_t e;
      e = strb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no strobe, required %h at cycle %0d", e.name, e.strb, e.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
